// File: rtl/mem_pkg.sv
// mem_pkg: memControl encodings, UART register addresses and bus-controller states
package mem_pkg;

    localparam logic [1:0]  MEM_IDLE       = 2'b00;
    localparam logic [1:0]  MEM_READ       = 2'b10;
    localparam logic [1:0]  MEM_WRITE      = 2'b01;
    localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
    localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;

    typedef enum logic [3:0] {
        S_IDLE, S_SR1, S_SR2, S_SW1, S_SW2, S_SW3, S_UR1, S_UR2, S_UW1, S_UW2, S_STAT
    } state_t;

    // States in which the access reports completion
    function automatic logic is_done_state(input state_t s);
        return s inside {S_SR2, S_SW3, S_UR2, S_UW2, S_STAT};
    endfunction

    // States in which store data owns the shared bus
    function automatic logic drives_bus(input state_t s);
        return s inside {S_SW1, S_SW2, S_SW3, S_UW1, S_UW2};
    endfunction

endpackage

// File: rtl/uart_bus_ctrl.sv
// uart_bus_ctrl: UART read/write/status sequencing and status word formation
module uart_bus_ctrl
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  state_t      i_state,
    input  state_t      i_next,
    input  logic [7:0]  i_bus_byte,
    input  logic        i_ready,
    input  logic        i_tbre,
    input  logic        i_tsre,
    output state_t      o_next,
    output logic        o_rdn,
    output logic        o_wrn,
    output logic [15:0] o_rx_word,
    output logic [15:0] o_status
);

    assign o_rx_word = {8'h00, i_bus_byte};
    assign o_status  = {14'b0, i_ready, i_tbre & i_tsre};

    // Each UART access is a strobe cycle followed by a release cycle; STAT ends at once
    always_comb o_next = i_state == S_UR1 ? S_UR2 : i_state == S_UW1 ? S_UW2 : S_IDLE;

    // Strobes are registered from the next state so they cannot glitch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_rdn <= 1'b1;
            o_wrn <= 1'b1;
        end else begin
            o_rdn <= i_next != S_UR1;
            o_wrn <= i_next != S_UW1;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage controller for the shared SRAM/UART data bus
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int                    RAM_ADDR_W = 18,
    parameter logic [RAM_ADDR_W-17:0] RAM_PAGE  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memReq,
    input  logic [1:0]            memControl,
    input  logic [15:0]           memAddr,
    input  logic [15:0]           memWData,
    output logic [15:0]           memRData,
    output logic                  memBusy,
    output logic                  memDone,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    inout  wire  [15:0]           ram_data,
    output logic                  ram_en_n,
    output logic                  ram_oe_n,
    output logic                  ram_we_n,
    output logic                  uart_rdn,
    output logic                  uart_wrn,
    input  logic                  uart_ready,
    input  logic                  uart_tbre,
    input  logic                  uart_tsre
);

    state_t      r_state, w_next, w_uart_next;
    logic [15:0] r_addr, r_wdata, w_rx_word, w_status;
    logic        r_drive, w_accept, w_read;

    assign w_read   = memControl == MEM_READ;
    assign w_accept = memReq && r_state == S_IDLE && (w_read || memControl == MEM_WRITE);
    assign ram_addr = {RAM_PAGE, r_addr};
    assign ram_data = r_drive ? r_wdata : 16'bz;

    uart_bus_ctrl u_uart (
        .clk        (clk),
        .rst        (rst),
        .i_state    (r_state),
        .i_next     (w_next),
        .i_bus_byte (ram_data[7:0]),
        .i_ready    (uart_ready),
        .i_tbre     (uart_tbre),
        .i_tsre     (uart_tsre),
        .o_next     (w_uart_next),
        .o_rdn      (uart_rdn),
        .o_wrn      (uart_wrn),
        .o_rx_word  (w_rx_word),
        .o_status   (w_status)
    );

    // Entry state picked by target and direction; SRAM sequences step here, UART ones in the sub-block
    always_comb begin
        case (r_state)
            S_IDLE:  w_next = !w_accept ? S_IDLE :
                              memAddr == UART_STAT_ADDR ? S_STAT :
                              memAddr == UART_DATA_ADDR ? (w_read ? S_UR1 : S_UW1) :
                              (w_read ? S_SR1 : S_SW1);
            S_SR1:   w_next = S_SR2;
            S_SW1:   w_next = S_SW2;
            S_SW2:   w_next = S_SW3;
            S_SR2,
            S_SW3:   w_next = S_IDLE;
            default: w_next = w_uart_next;
        endcase
    end

    // All outputs registered from the next state; load data captured on entry to the done state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_drive  <= 1'b0;
            memBusy  <= 1'b0;
            memDone  <= 1'b0;
            memRData <= '0;
            ram_en_n <= 1'b1;
            ram_oe_n <= 1'b1;
            ram_we_n <= 1'b1;
        end else begin
            r_state  <= w_next;
            r_drive  <= drives_bus(w_next);
            memBusy  <= w_next != S_IDLE;
            memDone  <= is_done_state(w_next);
            ram_en_n <= !(w_next inside {S_SR1, S_SW1, S_SW2, S_SW3});
            ram_oe_n <= w_next != S_SR1;
            ram_we_n <= w_next != S_SW2;
            if (w_accept) begin
                r_addr  <= memAddr;
                r_wdata <= memWData;
            end
            if (w_next == S_SR2)
                memRData <= ram_data;
            else if (w_next == S_UR2)
                memRData <= w_rx_word;
            else if (w_accept && w_read && w_next == S_STAT)
                memRData <= w_status;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed checks against a transaction-level model
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memReq = 1'b0;
    logic [1:0]  memControl = MEM_IDLE;
    logic [15:0] memAddr = '0;
    logic [15:0] memWData = '0;
    logic [15:0] memRData;
    logic        memBusy, memDone;
    logic [17:0] ram_addr;
    wire  [15:0] ram_data;
    logic        ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn;
    logic        uart_ready = 1'b0, uart_tbre = 1'b0, uart_tsre = 1'b0;
    logic [15:0] uart_rx = '0;
    logic [15:0] sram    [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] exp_rd = '0;
    logic        tb_drv;
    logic [15:0] tb_bus;
    int          n_checks = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    always_comb tb_drv = (!ram_en_n && !ram_oe_n) || !uart_rdn;
    always_comb tb_bus = !uart_rdn ? uart_rx : sram[ram_addr[15:0]];
    assign ram_data = tb_drv ? tb_bus : 16'bz;

    mem_access_unit dut (
        .clk        (clk),
        .rst        (rst),
        .memReq     (memReq),
        .memControl (memControl),
        .memAddr    (memAddr),
        .memWData   (memWData),
        .memRData   (memRData),
        .memBusy    (memBusy),
        .memDone    (memDone),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_en_n   (ram_en_n),
        .ram_oe_n   (ram_oe_n),
        .ram_we_n   (ram_we_n),
        .uart_rdn   (uart_rdn),
        .uart_wrn   (uart_wrn),
        .uart_ready (uart_ready),
        .uart_tbre  (uart_tbre),
        .uart_tsre  (uart_tsre)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request, observed for a fixed window; optionally a second request while busy, or a reset mid-access
    task automatic run_access(input logic [1:0] ctl, input logic [15:0] addr, input logic [15:0] wd,
                              input logic [15:0] rx, input bit inject, input int abort_at);
        bit valid, rd, stat, uart, sram_acc, en_ok;
        int lat, done_at, dcnt, bcnt, wecnt, wrncnt, rdncnt, ovl;
        logic [15:0] got_rd, got_bus, got_tx, exp_val;
        logic [17:0] addr_seen;
        valid    = ctl == MEM_READ || ctl == MEM_WRITE;
        rd       = ctl == MEM_READ;
        stat     = addr == UART_STAT_ADDR;
        uart     = addr == UART_DATA_ADDR;
        sram_acc = valid && !stat && !uart;
        lat      = !valid ? 0 : stat ? 1 : uart ? 2 : rd ? 2 : 3;
        exp_val  = stat ? {14'b0, uart_ready, uart_tbre & uart_tsre} : uart ? {8'h00, rx[7:0]} : ref_mem[addr];
        {done_at, dcnt, bcnt, wecnt, wrncnt, rdncnt, ovl} = '0;
        {got_rd, got_bus, got_tx, addr_seen} = '0;
        en_ok   = 1'b1;
        uart_rx = rx;
        @(negedge clk);
        memReq = 1'b1; memControl = ctl; memAddr = addr; memWData = wd;
        @(negedge clk);
        memReq = 1'b0; memControl = MEM_IDLE; memAddr = 16'($urandom); memWData = 16'($urandom);
        for (int c = 1; c <= 6; c++) begin
            if (memDone) begin
                dcnt++;
                if (done_at == 0) begin done_at = c; got_rd = memRData; end
            end
            if (memBusy) bcnt++;
            if (!ram_we_n) begin wecnt++; got_bus = ram_data; sram[ram_addr[15:0]] = ram_data; end
            if (!uart_wrn) begin wrncnt++; got_tx = ram_data; en_ok &= ram_en_n; end
            if (!uart_rdn) begin rdncnt++; en_ok &= ram_en_n; end
            if (!ram_en_n && (!uart_rdn || !uart_wrn)) ovl++;
            if (c == 1) addr_seen = ram_addr;
            if (c == abort_at) begin
                rst = 1'b0;
                #1;
                check("rst_strobes", {ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn}, 5'h1f);
                check("rst_busy_done", {memBusy, memDone}, 0);
                check("rst_rdata", memRData, 0);
                check("rst_addr", ram_addr, 0);
                check("rst_we_before", wecnt, 1);
                exp_rd = '0;
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            if (inject && c == 1) begin memReq = 1'b1; memControl = MEM_READ; memAddr = addr ^ 16'h0001; end
            if (inject && c == 2) begin memReq = 1'b0; memControl = MEM_IDLE; end
            @(negedge clk);
        end
        check("latency", done_at, lat);
        check("done_count", dcnt, valid ? 1 : 0);
        check("busy_cycles", bcnt, lat);
        check("we_low_cycles", wecnt, (sram_acc && !rd) ? 1 : 0);
        check("wrn_low_cycles", wrncnt, (valid && uart && !rd) ? 1 : 0);
        check("rdn_low_cycles", rdncnt, (valid && uart && rd) ? 1 : 0);
        check("strobe_overlap", ovl, 0);
        check("uart_en_high", en_ok, 1);
        if (valid && rd) begin
            check("rdata", got_rd, exp_val);
            exp_rd = exp_val;
        end
        if (sram_acc) check("ram_addr", addr_seen, {2'b00, addr});
        if (sram_acc && !rd) begin
            check("sram_wbus", got_bus, wd);
            ref_mem[addr] = wd;
        end
        if (valid && uart && !rd) check("uart_tx", got_tx, wd);
        check("rdata_hold", memRData, exp_rd);
    endtask

    initial begin
        logic [1:0]  ctl;
        logic [15:0] addr;
        for (int i = 0; i < 65536; i++) begin sram[i] = '0; ref_mem[i] = '0; end
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_strobes", {ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn}, 5'h1f);
        check("reset_busy_done", {memBusy, memDone}, 0);
        check("reset_rdata", memRData, 0);
        check("reset_addr", ram_addr, 0);
        rst = 1'b1;
        run_access(MEM_WRITE, 16'h1234, 16'hBEEF, 16'h0000, 0, 0);
        run_access(MEM_READ,  16'h1234, 16'h0000, 16'h0000, 0, 0);
        run_access(MEM_WRITE, UART_DATA_ADDR, 16'h0041, 16'h0000, 0, 0);
        uart_ready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b0;
        run_access(MEM_READ, UART_STAT_ADDR, 16'h0000, 16'h0000, 0, 0);
        uart_tsre = 1'b1;
        run_access(MEM_READ, UART_STAT_ADDR, 16'h0000, 16'h0000, 0, 0);
        run_access(MEM_READ, UART_DATA_ADDR, 16'h0000, 16'hFF5A, 0, 0);
        run_access(2'b11, 16'h1234, 16'h5555, 16'h0000, 0, 0);
        run_access(MEM_IDLE, 16'h1234, 16'h6666, 16'h0000, 0, 0);
        run_access(MEM_WRITE, 16'h2000, 16'hCAFE, 16'h0000, 1, 0);
        run_access(MEM_READ,  16'h2000, 16'h0000, 16'h0000, 0, 0);
        run_access(MEM_READ,  16'h2001, 16'h0000, 16'h0000, 0, 0);
        run_access(MEM_WRITE, UART_STAT_ADDR, 16'h7777, 16'h0000, 0, 0);
        run_access(MEM_WRITE, 16'h3000, 16'hA5A5, 16'h0000, 0, 2);
        run_access(MEM_WRITE, 16'h3000, 16'h1111, 16'h0000, 0, 0);
        run_access(MEM_READ,  16'h3000, 16'h0000, 16'h0000, 0, 0);
        run_access(MEM_READ,  16'h1234, 16'h0000, 16'h0000, 0, 0);
        for (int n = 0; n < 150; n++) begin
            int r, s;
            r = $urandom_range(0, 9);
            s = $urandom_range(0, 5);
            ctl  = r < 4 ? MEM_READ : r < 8 ? MEM_WRITE : r == 8 ? 2'b11 : MEM_IDLE;
            addr = s == 0 ? UART_DATA_ADDR : s == 1 ? UART_STAT_ADDR : 16'h0100 + 16'($urandom_range(0, 7));
            uart_ready = 1'($urandom); uart_tbre = 1'($urandom); uart_tsre = 1'($urandom);
            run_access(ctl, addr, 16'($urandom), 16'($urandom), 0, 0);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
